// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial adder sequencer driving one shared external half adder.
// Latency: 2*WIDTH cycles from the accept edge to out_valid, since each bit takes two half-adder passes, LSB first.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, then the block returns to IDLE.
// Optional feature macro: SERIAL_ADD_SUB_EN (sub=1 selects A-B via ~B plus carry-in 1).
// Ports: CLK/RST_N (async active-low); in_valid/in_ready/a_in/b_in/sub (operand handshake);
//        out_valid/out_ready/sum_out/cout_out (result handshake); ha_a/ha_b/ha_s/ha_c (shared half adder).
module serial_add_seq #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ha_a,
  output logic             ha_b,
  input  logic             ha_s,
  input  logic             ha_c
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PH0  = 2'd1;
  localparam logic [1:0] PH1  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             s1;
  logic             c1;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  // Operand B and carry-in as seen by the adder once accepted.
  logic [WIDTH-1:0] opb_next;
  logic             cin_next;

`ifdef SERIAL_ADD_SUB_EN
  assign opb_next = sub ? ~b_in : b_in;
  assign cin_next = sub;
`else
  // sub is kept on the port for pin compatibility but has no function here.
  logic sub_unused;
  assign sub_unused = sub;
  assign opb_next   = b_in;
  assign cin_next   = 1'b0;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // PH0 adds the two operand bits; PH1 folds the running carry into that partial sum.
  always_comb begin
    ha_a = 1'b0;
    ha_b = 1'b0;
    case (state)
      PH0: begin
        ha_a = opa[idx];
        ha_b = opb[idx];
      end
      PH1: begin
        ha_a = s1;
        ha_b = carry;
      end
      default: begin
        ha_a = 1'b0;
        ha_b = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      s1       <= 1'b0;
      c1       <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa     <= a_in;
            opb     <= opb_next;
            carry   <= cin_next;
            idx     <= '0;
            sum_out <= '0;
            state   <= PH0;
          end
        end
        PH0: begin
          s1    <= ha_s;
          c1    <= ha_c;
          state <= PH1;
        end
        PH1: begin
          sum_out[idx] <= ha_s;
          // At most one of c1 and ha_c can be set, so OR is the full-adder carry.
          carry        <= c1 | ha_c;
          if (idx == LAST_IDX) begin
            cout_out <= c1 | ha_c;
            state    <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= PH0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: table-driven and random checks of serial_add_seq (WIDTH=4).
// The half adder on ha_* is a plain combinational model; expectations come from integer arithmetic.
// Ports: all DUT ports driven or observed from this module.
module tb_serial_add_seq;

  localparam int W = 4;
`ifdef SERIAL_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         CLK;
  logic         RST_N;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_out;
  logic         cout_out;
  logic         ha_a;
  logic         ha_b;
  logic         ha_s;
  logic         ha_c;

  int n_pass  = 0;
  int n_total = 0;

  serial_add_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .cout_out(cout_out),
    .ha_a(ha_a), .ha_b(ha_b), .ha_s(ha_s), .ha_c(ha_c)
  );

  // The shared half adder.
  assign ha_s = ha_a ^ ha_b;
  assign ha_c = ha_a & ha_b;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int a;
    int b;
    bit s;
    int exp_sum;
    int exp_cout;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference result: {cout,sum} as a 5-bit integer.
  function automatic int model(input int a, input int b, input bit s);
    if (SUB_EN && s) return a - b + 16;  // bit 4 set exactly when a >= b
    return a + b;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, " in_ready"},  in_ready,  1);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " sum_out"},   sum_out,   0);
    check({tag, " cout_out"},  cout_out,  0);
    check({tag, " ha_a"},      ha_a,      0);
    check({tag, " ha_b"},      ha_b,      0);
  endtask

  task automatic run_op(input int a, input int b, input bit s, input int hold,
                        input bit disturb, input int exp_sum, input int exp_cout,
                        input string tag);
    int lat;
    int beff;
    int cin;
    int bi;
    bit timed_out;
    beff = (SUB_EN && s) ? 15 - b : b;
    cin  = (SUB_EN && s) ? 1 : 0;
    timed_out = 1'b0;
    @(negedge CLK);
    check({tag, " in_ready idle"}, in_ready, 1);
    a_in = W'(a); b_in = W'(b); sub = s; in_valid = 1'b1;
    @(posedge CLK);
    lat = 0;
    while (1) begin
      @(negedge CLK);
      in_valid = 1'b0;
      if (out_valid) break;
      if (lat >= 40) begin
        check({tag, " timeout"}, lat, 2 * W);
        timed_out = 1'b1;
        break;
      end
      if (lat == 0) begin
        check({tag, " in_ready busy"}, in_ready, 0);
        check({tag, " sum cleared"}, sum_out, 0);
      end
      bi = lat / 2;
      if (lat % 2 == 0) begin
        check({tag, " ha_a ph0"}, ha_a, (a >> bi) & 1);
        check({tag, " ha_b ph0"}, ha_b, (beff >> bi) & 1);
      end else begin
        check({tag, " ha_a ph1"}, ha_a, ((a ^ beff) >> bi) & 1);
        check({tag, " ha_b ph1"}, ha_b,
              (((a % (1 << bi)) + (beff % (1 << bi)) + cin) >> bi) & 1);
      end
      if (disturb) begin
        in_valid = 1'($urandom);
        a_in = W'($urandom);
        b_in = W'($urandom);
        sub = 1'($urandom);
      end
      @(posedge CLK);
      lat++;
    end
    if (timed_out) return;
    check({tag, " latency"}, lat, 2 * W);
    check({tag, " sum_out"}, sum_out, exp_sum);
    check({tag, " cout_out"}, cout_out, exp_cout);
    check({tag, " ha_a done"}, ha_a, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK);
      @(negedge CLK);
      check({tag, " held valid"}, out_valid, 1);
      check({tag, " held sum"}, sum_out, exp_sum);
      check({tag, " held cout"}, cout_out, exp_cout);
    end
    out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    out_ready = 1'b0;
    check({tag, " out_valid clr"}, out_valid, 0);
    check({tag, " in_ready back"}, in_ready, 1);
  endtask

  vec_t vecs[$];

  initial begin
    int a;
    int b;
    bit s;
    int r;

    vecs.push_back('{3, 5, 1'b0, 8, 0});
    vecs.push_back('{15, 1, 1'b0, 0, 1});
    vecs.push_back('{0, 0, 1'b0, 0, 0});
    vecs.push_back('{15, 15, 1'b0, 14, 1});
    vecs.push_back('{10, 5, 1'b0, 15, 0});
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back('{5, 3, 1'b1, 2, 1});
    vecs.push_back('{3, 5, 1'b1, 14, 0});
    vecs.push_back('{4, 4, 1'b1, 0, 1});
`else
    vecs.push_back('{3, 5, 1'b1, 8, 0});
    vecs.push_back('{12, 4, 1'b1, 0, 1});
`endif

    RST_N = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; sub = 1'b0;
    #12;
    check_reset_vals("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, 0, 1'b0,
             vecs[i].exp_sum, vecs[i].exp_cout, $sformatf("vec%0d", i));

    // Result held while the consumer stalls in DONE.
    run_op(9, 6, 1'b0, 5, 1'b0, 15, 0, "hold");

    // Input activity while busy must not disturb the accepted operands.
    run_op(10, 3, 1'b0, 1, 1'b1, 13, 0, "busy");

    // out_ready while idle has no effect.
    @(negedge CLK);
    out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    out_ready = 1'b0;
    check("idle out_ready in_ready", in_ready, 1);
    check("idle out_ready out_valid", out_valid, 0);

    // Reset in the middle of an operation aborts at once.
    @(negedge CLK);
    a_in = 4'd6; b_in = 4'd9; sub = 1'b0; in_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(negedge CLK);
    RST_N = 1'b1;
    run_op(7, 7, 1'b0, 0, 1'b0, 14, 0, "after_reset");

    for (int k = 0; k < 40; k++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      s = 1'($urandom);
      r = model(a, b, s);
      run_op(a, b, s, int'($urandom_range(0, 3)), 1'($urandom),
             r % 16, (r >> 4) & 1, $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
